// File: rtl/sdf_arbiter.sv
// sdf_arbiter: shares one fixed-latency SDF pipeline among NUM_REQ ray requesters.
// Grants one requester per cycle, registers its point into the SDF unit and tags
// the issue so the result returns to the right requester SDF_LATENCY+2 cycles
// after the transfer.
// Optional macro SDF_ARB_ROUND_ROBIN_EN: round-robin arbitration instead of the
// default fixed priority (lowest index wins).
module sdf_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned SDF_LATENCY = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [27*NUM_REQ-1:0]  req_x,
  input  logic [27*NUM_REQ-1:0]  req_y,
  input  logic [27*NUM_REQ-1:0]  req_z,
  output logic [26:0]            sdf_x,
  output logic [26:0]            sdf_y,
  output logic [26:0]            sdf_z,
  output logic                   sdf_valid,
  input  logic [26:0]            sdf_distance,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [26:0]            resp_distance
);

  localparam int unsigned FW    = 27;
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   iss_idx;
  logic [SDF_LATENCY-1:0] tag_v;
  logic [IDX_W-1:0]   tag_idx [SDF_LATENCY];

`ifdef SDF_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W:0]     cand;

  // Round-robin pick: first valid requester at or after the pointer, wrapping.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (IDX_W+1)'(ptr) + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!gnt_any && req_valid[cand[IDX_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Pointer moves just past the requester that was served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
    end
  end
`else
  // Fixed priority: lowest-index valid requester wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req_valid[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IDX_W'(k);
      end
    end
  end
`endif

  // One-hot grant, suppressed while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (gnt_any && !reset) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Operand register: capture the granted point; hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sdf_valid <= 1'b0;
      sdf_x     <= '0;
      sdf_y     <= '0;
      sdf_z     <= '0;
      iss_idx   <= '0;
    end else begin
      sdf_valid <= gnt_any;
      if (gnt_any) begin
        sdf_x   <= req_x[FW*gnt_idx +: FW];
        sdf_y   <= req_y[FW*gnt_idx +: FW];
        sdf_z   <= req_z[FW*gnt_idx +: FW];
        iss_idx <= gnt_idx;
      end
    end
  end

  // Tag pipeline tracking each issue through the SDF unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      for (int unsigned k = 0; k < SDF_LATENCY; k++) begin
        tag_idx[k] <= '0;
      end
    end else begin
      tag_v[0]   <= sdf_valid;
      tag_idx[0] <= iss_idx;
      for (int unsigned k = 1; k < SDF_LATENCY; k++) begin
        tag_v[k]   <= tag_v[k-1];
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  // Response register: route the returning distance to its requester.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid    <= '0;
      resp_distance <= '0;
    end else begin
      resp_valid <= '0;
      if (tag_v[SDF_LATENCY-1]) begin
        resp_valid    <= NUM_REQ'(1) << tag_idx[SDF_LATENCY-1];
        resp_distance <= sdf_distance;
      end
    end
  end

endmodule

// File: tb/tb_sdf_arbiter.sv
// tb_sdf_arbiter: directed and random stimulus against a queue/array reference
// model of the arbiter; the SDF unit is a 5-cycle registered delay of sdf_x.
module tb_sdf_arbiter;

  localparam int N    = 4;
  localparam int L    = 5;
  localparam int W    = 27;
  localparam int RING = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_ready, resp_valid;
  logic [W*N-1:0] req_x, req_y, req_z;
  logic [W-1:0]   sdf_x, sdf_y, sdf_z, sdf_distance, resp_distance;
  logic           sdf_valid;
  logic [W-1:0]   dly [L];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int ptr    = 0;

  logic           m_sv;
  logic [W-1:0]   m_sx, m_sy, m_sz, m_rd;
  logic [N-1:0]   ring_rv [RING];
  logic [W-1:0]   ring_rd [RING];

  always #5 clk = ~clk;

  sdf_arbiter #(.NUM_REQ(N), .SDF_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .sdf_x(sdf_x), .sdf_y(sdf_y), .sdf_z(sdf_z), .sdf_valid(sdf_valid),
    .sdf_distance(sdf_distance),
    .resp_valid(resp_valid), .resp_distance(resp_distance)
  );

  // SDF unit model: distance is sdf_x delayed by L registers.
  always @(posedge clk) begin
    dly[0] <= sdf_x;
    for (int i = 1; i < L; i++) dly[i] <= dly[i-1];
  end
  assign sdf_distance = dly[L-1];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle %0d observed %h expected %h", tag, cyc, obs, exp);
  endtask

  // Reference grant: first valid index scanning upward from p, wrapping.
  function automatic int model_grant(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // One cycle: check registered outputs, drive requests, check grant, update model.
  task automatic step(input logic [N-1:0] v, input logic fix_en, input logic [W-1:0] fix_x);
    int           g;
    int           slot;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] exp_rv;
    slot   = cyc % RING;
    exp_rv = ring_rv[slot];
    if (exp_rv != '0) m_rd = ring_rd[slot];
    check("sdf_valid", W'(sdf_valid), W'(m_sv));
    check("sdf_x", sdf_x, m_sx);
    check("sdf_y", sdf_y, m_sy);
    check("sdf_z", sdf_z, m_sz);
    check("resp_valid", W'(resp_valid), W'(exp_rv));
    check("resp_distance", resp_distance, m_rd);
    ring_rv[slot] = '0;

    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_x[W*i +: W] = W'($urandom);
      req_y[W*i +: W] = W'($urandom);
      req_z[W*i +: W] = W'($urandom);
    end
    if (fix_en) req_x[W*2 +: W] = fix_x;
    #1;
    g       = model_grant(v, ptr);
    exp_rdy = (g >= 0) ? (N'(1) << g) : '0;
    check("req_ready", W'(req_ready), W'(exp_rdy));

    m_sv = (g >= 0);
    if (g >= 0) begin
      m_sx = req_x[W*g +: W];
      m_sy = req_y[W*g +: W];
      m_sz = req_z[W*g +: W];
      ring_rv[(cyc + L + 2) % RING] = exp_rdy;
      ring_rd[(cyc + L + 2) % RING] = m_sx;
`ifdef SDF_ARB_ROUND_ROBIN_EN
      ptr = (g + 1) % N;
`endif
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset for n cycles with requests pending; everything must read zero.
  task automatic do_reset(input int n);
    reset     = 1'b1;
    req_valid = '1;
    #1;
    ptr  = 0;
    m_sv = 1'b0;
    m_sx = '0;
    m_sy = '0;
    m_sz = '0;
    m_rd = '0;
    for (int i = 0; i < RING; i++) ring_rv[i] = '0;
    for (int c = 0; c < n; c++) begin
      check("rst_req_ready", W'(req_ready), '0);
      check("rst_sdf_valid", W'(sdf_valid), '0);
      check("rst_sdf_x", sdf_x, '0);
      check("rst_sdf_y", sdf_y, '0);
      check("rst_sdf_z", sdf_z, '0);
      check("rst_resp_valid", W'(resp_valid), '0);
      check("rst_resp_distance", resp_distance, '0);
      @(posedge clk);
      #1;
      cyc++;
    end
    reset     = 1'b0;
    req_valid = '0;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    req_z     = '0;
    #2;
    do_reset(3);

    // Idle after reset.
    for (int i = 0; i < 20; i++) step('0, 1'b0, '0);

    // Single request from requester 2 with a known operand.
    step(4'b0100, 1'b1, 27'h1fc0000);
    for (int i = 0; i < 9; i++) step('0, 1'b0, '0);

    // All requesters valid continuously.
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, '0);
    for (int i = 0; i < 9; i++) step('0, 1'b0, '0);

    // Serve requester 0, then requester 1 drops as it would be next in line.
    step(4'b0001, 1'b0, '0);
    step(4'b1101, 1'b0, '0);
    for (int i = 0; i < 9; i++) step('0, 1'b0, '0);

    // Issues in flight when reset hits must never respond.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, '0);
    do_reset(2);
    for (int i = 0; i < 10; i++) step('0, 1'b0, '0);

    // Random traffic.
    for (int i = 0; i < 300; i++) step(N'($urandom), 1'b0, '0);
    for (int i = 0; i < 10; i++) step('0, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sdf_arbiter.md
SDF_ARBITER -- requirements
Module: sdf_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of ray requesters sharing one SDF pipeline (2..8).
REQ-002 SHALL have parameter SDF_LATENCY, default 5, fixed cycle latency of the attached SDF unit (1..16).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester point-valid.
REQ-006 SHALL have port req_ready  output  NUM_REQ  per-requester grant, one-hot or zero.
REQ-007 SHALL have port req_x, req_y, req_z  input  27*NUM_REQ each  packed 27-bit float points; requester i occupies bits [27i+26:27i].
REQ-008 SHALL have port sdf_x, sdf_y, sdf_z  output  27 each  registered operands to SDF unit.
REQ-009 SHALL have port sdf_valid  output  1  operands on sdf_* are a live issue.
REQ-010 SHALL have port sdf_distance  input  27  SDF result, valid SDF_LATENCY cycles after issue.
REQ-011 SHALL have port resp_valid  output  NUM_REQ  one-hot result strobe, single cycle.
REQ-012 SHALL have port resp_distance  output  27  result for requester flagged in resp_valid.

Function
REQ-013 SHALL compute req_ready combinationally from req_valid and priority state; at most one bit high, and only for a requester with req_valid high.
REQ-014 SHALL treat a transfer as req_valid[i] and req_ready[i] both high at a rising edge; one transfer per cycle maximum.
REQ-015 SHALL, on transfer from requester i in cycle t, drive sdf_x/y/z with that requester's point and sdf_valid=1 in cycle t+1; otherwise sdf_valid=0 and sdf_* hold last value.
REQ-016 SHALL carry a tag (valid bit plus requester index, width clog2(NUM_REQ)) in a SDF_LATENCY-deep shift register advanced every cycle, aligned with sdf_valid.
REQ-017 SHALL, when the tag exits the shift register (cycle t+1+SDF_LATENCY), register sdf_distance into resp_distance and set resp_valid[tag]=1 in cycle t+2+SDF_LATENCY; total latency SDF_LATENCY+2 from transfer.
REQ-018 SHALL hold resp_valid at zero in cycles with no exiting tag; resp_distance holds its last value.
REQ-019 SHALL apply no backpressure on responses; requesters must accept resp_valid in the cycle presented.
REQ-020 SHALL sustain one issue per cycle with back-to-back transfers from any mix of requesters; results return in issue order.
REQ-021 SHALL not alter sign, exponent or mantissa of any 27-bit value passing through.
REQ-022 SHALL grant nothing and issue nothing when req_valid is all zero; the tag pipeline still drains.

Reset
REQ-023 SHALL, while reset is high, force req_ready=0, sdf_valid=0, sdf_x/y/z=0, resp_valid=0, resp_distance=0, all tag valid bits=0, priority pointer=0.
REQ-024 SHALL discard all in-flight results on reset assertion; no resp_valid for any issue made before reset.
REQ-025 SHALL accept transfers from the first rising edge after reset deasserts.

Configuration
REQ-026 SHALL, with macro SDF_ARB_ROUND_ROBIN_EN defined, use round-robin: pointer p starts at 0; grant lowest index >= p (wrapping) with req_valid high; after transfer from i, p becomes (i+1) mod NUM_REQ.
REQ-027 SHALL, without SDF_ARB_ROUND_ROBIN_EN, use fixed priority: lowest-index valid requester wins; no pointer state.

Verification (NUM_REQ=4, SDF_LATENCY=5, SDF model = registered delay of sdf_x by 5)
REQ-028 SHALL cover: single request req_valid=4'b0100, req_x[2]=27'h1fc0000 at cycle 0 -> req_ready=4'b0100 cycle 0, sdf_valid cycle 1, resp_valid=4'b0100 with resp_distance=27'h1fc0000 at cycle 7.
REQ-029 SHALL cover: all four valid continuously with round-robin enabled -> grants 0,1,2,3,0 on cycles 0..4; responses in same order on cycles 7..11.
REQ-030 SHALL cover: all four valid with macro undefined -> requester 0 granted every cycle, others req_ready=0.
REQ-031 SHALL cover: reset asserted at cycle 3 after issues at cycles 0..2 -> no resp_valid ever for those issues; all outputs zero during reset.
REQ-032 SHALL cover: requester 1 drops req_valid in same cycle pointer points at it -> grant goes to requester 2; no grant to an invalid requester.
REQ-033 SHALL cover: idle req_valid=0 for 20 cycles after reset -> req_ready, sdf_valid, resp_valid remain zero.
